mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the core's instruction-fetch port (imem) and data port (dmem) in the rv32 1-stage tile.
- Sits between core and memory; presents two requester-side MemPortIo-style ports and one memory-side port.
- Allows one outstanding transaction at a time.
- Fixed priority to dmem, with a starvation guard that guarantees fetch forward progress.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/mem_arb_prio.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 tile definitions: memory command encodings and arbiter enums.
package rv32_pkg;

    localparam logic       M_XRD = 1'b0;
    localparam logic       M_XWR = 1'b1;

    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic {OWN_IMEM, OWN_DMEM} owner_t;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant picker for the shared memory port: dmem wins unless imem has
// already lost STARVE_MAX handshakes in a row while waiting.
module mem_arb_prio
    import rv32_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic imem_valid,
    input  logic dmem_valid,
    input  logic handshake,
    output logic grant_imem,
    output logic grant_dmem
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    // Combinational grant from the current valids and starvation count.
    always_comb begin
        grant_dmem = dmem_valid && ((starve_cnt < STARVE_LIM) || !imem_valid);
        grant_imem = imem_valid && !grant_dmem;
    end

    // Count dmem wins over a waiting imem; any other handshake clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (handshake) begin
            if (grant_dmem && imem_valid) begin
                if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports,
// one outstanding transaction at a time.
//
//   state    | meaning
//   ARB_IDLE | may issue a request from the granted port
//   ARB_BUSY | request accepted, waiting for mem_resp_valid
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req_valid,
    output logic              imem_req_ready,
    input  logic [ADDR_W-1:0] imem_req_addr,
    output logic              imem_resp_valid,
    output logic [XLEN-1:0]   imem_resp_data,
    input  logic              dmem_req_valid,
    output logic              dmem_req_ready,
    input  logic [ADDR_W-1:0] dmem_req_addr,
    input  logic              dmem_req_fcn,
    input  logic [2:0]        dmem_req_typ,
    input  logic [XLEN-1:0]   dmem_req_wdata,
    output logic              dmem_resp_valid,
    output logic [XLEN-1:0]   dmem_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_fcn,
    output logic [2:0]        mem_req_typ,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              busy
);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    logic       arb_open;
    logic       grant_imem, grant_dmem;
    logic       handshake;

    // Arbitration only runs in IDLE; a reset cycle grants nothing.
    assign arb_open  = (state_q == ARB_IDLE) && !rst;
    assign handshake = mem_req_valid && mem_req_ready;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .imem_valid (imem_req_valid && arb_open),
        .dmem_valid (dmem_req_valid && arb_open),
        .handshake  (handshake),
        .grant_imem (grant_imem),
        .grant_dmem (grant_dmem)
    );

    // State and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IMEM;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next state, request mux and response routing; every output idles at 0.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        mem_req_fcn     = M_XRD;
        mem_req_typ     = MT_X;
        mem_req_wdata   = '0;
        imem_req_ready  = 1'b0;
        dmem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = '0;
        busy            = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant_dmem) begin
                        mem_req_valid  = 1'b1;
                        mem_req_addr   = dmem_req_addr;
                        mem_req_fcn    = dmem_req_fcn;
                        mem_req_typ    = dmem_req_typ;
                        mem_req_wdata  = dmem_req_wdata;
                        dmem_req_ready = mem_req_ready;
                    end else if (grant_imem) begin
                        mem_req_valid  = 1'b1;
                        mem_req_addr   = imem_req_addr;
                        mem_req_fcn    = M_XRD;
                        mem_req_typ    = MT_W;
                        imem_req_ready = mem_req_ready;
                    end
                    if (handshake) begin
                        state_d = ARB_BUSY;
                        owner_d = grant_dmem ? OWN_DMEM : OWN_IMEM;
                    end
                end
                ARB_BUSY: begin
                    busy = 1'b1;
                    if (mem_resp_valid) begin
                        state_d = ARB_IDLE;
                        if (owner_q == OWN_DMEM) begin
                            dmem_resp_valid = 1'b1;
                            dmem_resp_data  = mem_resp_data;
                        end else begin
                            imem_resp_valid = 1'b1;
                            imem_resp_data  = mem_resp_data;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked cycle by cycle against a behavioural model.
module tb_mem_port_arbiter;
    import rv32_pkg::*;

    localparam int XLEN = 32, ADDR_W = 32, STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid, imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [XLEN-1:0]   imem_resp_data;
    logic              dmem_req_valid, dmem_req_ready;
    logic [ADDR_W-1:0] dmem_req_addr;
    logic              dmem_req_fcn;
    logic [2:0]        dmem_req_typ;
    logic [XLEN-1:0]   dmem_req_wdata;
    logic              dmem_resp_valid;
    logic [XLEN-1:0]   dmem_resp_data;
    logic              mem_req_valid, mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_fcn;
    logic [2:0]        mem_req_typ;
    logic [XLEN-1:0]   mem_req_wdata;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;
    logic              busy;

    mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(dmem_req_addr), .dmem_req_fcn(dmem_req_fcn),
        .dmem_req_typ(dmem_req_typ), .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_fcn(mem_req_fcn),
        .mem_req_typ(mem_req_typ), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // The port is either free or held by one requester until the memory
    // answers. imem_losses counts how many handshakes dmem has won in a row
    // while imem was asking; at STARVE_MAX imem is owed the next one.
    bit m_held = 0;
    bit m_held_by_d = 0;
    int imem_losses = 0;

    always @(negedge clk) begin
        logic e_mv, e_fcn, e_ir, e_dr, e_iv, e_dv, e_busy, want_d, want_i;
        logic [ADDR_W-1:0] e_addr;
        logic [2:0]        e_typ;
        logic [XLEN-1:0]   e_wd, e_id, e_dd;
        e_mv = 0; e_fcn = 0; e_ir = 0; e_dr = 0; e_iv = 0; e_dv = 0; e_busy = 0;
        e_addr = '0; e_typ = '0; e_wd = '0; e_id = '0; e_dd = '0;
        want_d = 0; want_i = 0;
        if (rst) begin
            m_held = 0;
            imem_losses = 0;
        end else if (!m_held) begin
            want_d = dmem_req_valid && (imem_losses < STARVE_MAX || !imem_req_valid);
            want_i = imem_req_valid && !want_d;
            if (want_d) begin
                e_mv = 1; e_addr = dmem_req_addr; e_fcn = dmem_req_fcn;
                e_typ = dmem_req_typ; e_wd = dmem_req_wdata; e_dr = mem_req_ready;
            end else if (want_i) begin
                e_mv = 1; e_addr = imem_req_addr; e_fcn = M_XRD; e_typ = MT_W;
                e_ir = mem_req_ready;
            end
            if (e_mv && mem_req_ready) begin
                m_held = 1;
                m_held_by_d = want_d;
                if (want_d && imem_req_valid)
                    imem_losses = (imem_losses < STARVE_MAX) ? imem_losses + 1 : imem_losses;
                else
                    imem_losses = 0;
            end
        end else begin
            e_busy = 1;
            if (mem_resp_valid) begin
                if (m_held_by_d) begin e_dv = 1; e_dd = mem_resp_data; end
                else             begin e_iv = 1; e_id = mem_resp_data; end
                m_held = 0;
            end
        end
        chk("mem_req_valid",   64'(mem_req_valid),   64'(e_mv));
        chk("mem_req_addr",    64'(mem_req_addr),    64'(e_addr));
        chk("mem_req_fcn",     64'(mem_req_fcn),     64'(e_fcn));
        chk("mem_req_typ",     64'(mem_req_typ),     64'(e_typ));
        chk("mem_req_wdata",   64'(mem_req_wdata),   64'(e_wd));
        chk("imem_req_ready",  64'(imem_req_ready),  64'(e_ir));
        chk("dmem_req_ready",  64'(dmem_req_ready),  64'(e_dr));
        chk("imem_resp_valid", 64'(imem_resp_valid), 64'(e_iv));
        chk("imem_resp_data",  64'(imem_resp_data),  64'(e_id));
        chk("dmem_resp_valid", 64'(dmem_resp_valid), 64'(e_dv));
        chk("dmem_resp_data",  64'(dmem_resp_data),  64'(e_dd));
        chk("busy",            64'(busy),            64'(e_busy));
    end

    // ---------------- stimulus: requesters and memory ----------------
    int  resp_wait = 0;
    int  lat = 1;
    bit  rand_mode = 0;
    bit  spurious = 0;
    bit  force_data = 0;
    logic [XLEN-1:0] fdata = '0;
    bit  acc_i, acc_d, acc_m;

    task automatic new_imem();
        imem_req_addr = $urandom;
    endtask

    task automatic new_dmem();
        dmem_req_addr  = $urandom;
        dmem_req_fcn   = 1'($urandom);
        dmem_req_typ   = 3'($urandom);
        dmem_req_wdata = $urandom;
    endtask

    task automatic to_neg();
        @(negedge clk);
        acc_i = imem_req_valid && imem_req_ready;
        acc_d = dmem_req_valid && dmem_req_ready;
        acc_m = mem_req_valid && mem_req_ready;
    endtask

    task automatic from_neg();
        @(posedge clk);
        #1;
        if (rst) resp_wait = 0;
        else if (acc_m) resp_wait = rand_mode ? 1 + int'($urandom % 4) : lat;
        mem_resp_valid = 0;
        mem_resp_data  = $urandom;
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                mem_resp_valid = 1;
                if (force_data) mem_resp_data = fdata;
            end
        end else if (spurious || (rand_mode && ($urandom % 30 == 0))) begin
            mem_resp_valid = 1;
        end
        spurious = 0;
        if (rand_mode) begin
            if (acc_i) begin imem_req_valid = 1'($urandom); new_imem(); end
            else if (imem_req_valid) begin if ($urandom % 20 == 0) imem_req_valid = 0; end
            else if ($urandom % 3 == 0) begin imem_req_valid = 1; new_imem(); end
            if (acc_d) begin dmem_req_valid = 1'($urandom); new_dmem(); end
            else if (dmem_req_valid) begin if ($urandom % 20 == 0) dmem_req_valid = 0; end
            else if ($urandom % 2 == 0) begin dmem_req_valid = 1; new_dmem(); end
            mem_req_ready = ($urandom % 4 != 0);
            rst = ($urandom % 300 == 0);
        end
    endtask

    task automatic step();
        to_neg();
        from_neg();
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        int pulses, busy_cyc, rdys, grants;
        logic [9:0] order;
        rst = 1;
        imem_req_valid = 0; imem_req_addr = '0;
        dmem_req_valid = 0; dmem_req_addr = '0; dmem_req_fcn = 0;
        dmem_req_typ = '0; dmem_req_wdata = '0;
        mem_req_ready = 1; mem_resp_valid = 0; mem_resp_data = '0;
        step(); step();
        rst = 0;

        // Reset state.
        to_neg();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        from_neg();

        // Fetch only, 1-cycle memory.
        imem_req_valid = 1; imem_req_addr = 32'h100;
        force_data = 1; fdata = 32'hDEADBEEF; lat = 1;
        to_neg();
        chk("t1_imem_ready", 64'(imem_req_ready), 64'd1);
        chk("t1_addr", 64'(mem_req_addr), 64'h100);
        chk("t1_typ", 64'(mem_req_typ), 64'd3);
        chk("t1_fcn", 64'(mem_req_fcn), 64'd0);
        from_neg();
        imem_req_valid = 0;
        to_neg();
        chk("t1_resp_valid", 64'(imem_resp_valid), 64'd1);
        chk("t1_resp_data", 64'(imem_resp_data), 64'hDEADBEEF);
        chk("t1_dmem_resp", 64'(dmem_resp_valid), 64'd0);
        from_neg();
        force_data = 0;
        to_neg();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        from_neg();

        // Halfword store, 3-cycle memory.
        dmem_req_valid = 1; dmem_req_addr = 32'h200; dmem_req_fcn = 1;
        dmem_req_typ = 3'd2; dmem_req_wdata = 32'h12345678; lat = 3;
        to_neg();
        chk("t2_addr", 64'(mem_req_addr), 64'h200);
        chk("t2_fcn", 64'(mem_req_fcn), 64'd1);
        chk("t2_typ", 64'(mem_req_typ), 64'd2);
        chk("t2_wdata", 64'(mem_req_wdata), 64'h12345678);
        chk("t2_busy_at_req", 64'(busy), 64'd0);
        from_neg();
        dmem_req_valid = 0;
        pulses = 0; busy_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            to_neg();
            pulses += int'(dmem_resp_valid);
            busy_cyc += int'(busy);
            from_neg();
        end
        chk("t2_resp_pulses", 64'(pulses), 64'd1);
        chk("t2_busy_cycles", 64'(busy_cyc), 64'd3);

        // Both requesters always asking: starvation guard ordering.
        do_reset();
        lat = 1; imem_req_valid = 1; dmem_req_valid = 1;
        grants = 0; order = '0;
        for (int i = 0; i < 40 && grants < 10; i++) begin
            to_neg();
            if (acc_m) begin order = {order[8:0], acc_d}; grants++; end
            from_neg();
        end
        chk("t3_grant_count", 64'(grants), 64'd10);
        chk("t3_grant_order", 64'(order), 64'(10'b1111011110));

        // mem_req_ready low for 3 idle cycles must not disturb the count.
        do_reset();
        for (int i = 0; i < 6; i++) step();
        mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("t4_dmem_ready_low", 64'(dmem_req_ready), 64'd0);
            chk("t4_imem_ready_low", 64'(imem_req_ready), 64'd0);
            from_neg();
        end
        mem_req_ready = 1;
        to_neg();
        chk("t4_fourth_dmem", 64'(dmem_req_ready), 64'd1);
        from_neg();
        step();
        to_neg();
        chk("t4_then_imem", 64'(imem_req_ready), 64'd1);
        from_neg();
        imem_req_valid = 0; dmem_req_valid = 0;
        step(); step();
        spurious = 1;
        step();
        to_neg();
        chk("t4_spur_imem", 64'(imem_resp_valid), 64'd0);
        chk("t4_spur_dmem", 64'(dmem_resp_valid), 64'd0);
        from_neg();

        // Reset while a request is outstanding.
        dmem_req_valid = 1; lat = 5;
        step();
        dmem_req_valid = 0;
        step(); step();
        rst = 1;
        to_neg();
        chk("t5_rst_dresp", 64'(dmem_resp_valid), 64'd0);
        from_neg();
        rst = 0;
        to_neg();
        chk("t5_after_busy", 64'(busy), 64'd0);
        from_neg();
        imem_req_valid = 1; imem_req_addr = 32'h300; lat = 1;
        to_neg();
        chk("t5_fresh_ready", 64'(imem_req_ready), 64'd1);
        from_neg();
        imem_req_valid = 0;
        to_neg();
        chk("t5_fresh_resp", 64'(imem_resp_valid), 64'd1);
        from_neg();

        // 5-cycle memory with dmem re-requesting straight away.
        dmem_req_valid = 1; dmem_req_fcn = 0; lat = 5;
        to_neg();
        chk("t6_accept", 64'(dmem_req_ready), 64'd1);
        from_neg();
        rdys = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            rdys += int'(dmem_req_ready) + int'(imem_req_ready);
            pulses += int'(dmem_resp_valid);
            from_neg();
        end
        chk("t6_ready_in_busy", 64'(rdys), 64'd0);
        chk("t6_pulses", 64'(pulses), 64'd1);
        to_neg();
        chk("t6_next_grant", 64'(dmem_req_ready), 64'd1);
        from_neg();
        dmem_req_valid = 0;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic.
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        rand_mode = 0;
        rst = 0; imem_req_valid = 0; dmem_req_valid = 0; mem_req_ready = 1;
        for (int i = 0; i < 10; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
